// File: rtl/timer_pkg.sv
// Shared types and constants for the keypad-to-time entry path.
package timer_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam int unsigned BCD_W    = 4;

    localparam logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_e;

    // Entered time as displayed: m:ts
    typedef struct packed {
        logic [BCD_W-1:0] mins;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } time_t;

    // Seconds-tens can never exceed 5, so a larger ones digit saturates on shift
    function automatic logic [BCD_W-1:0] clamp_tens(input logic [BCD_W-1:0] d);
        return (d > MAX_SEC_TENS) ? MAX_SEC_TENS : d;
    endfunction

    // Microwave-style entry: new digit enters at the right, oldest minute digit drops off
    function automatic time_t shift_in(input time_t t, input logic [BCD_W-1:0] d);
        time_t r;
        r.mins     = t.sec_tens;
        r.sec_tens = clamp_tens(t.sec_ones);
        r.sec_ones = d;
        return r;
    endfunction

endpackage

// File: rtl/keypad_onehot_to_bcd.sv
// Combinational one-hot keypad decoder: BCD value plus an exactly-one-key flag.
module keypad_onehot_to_bcd
    import timer_pkg::*;
(
    input  logic [NUM_KEYS-1:0] keypad,
    output logic [BCD_W-1:0]    bcd,
    output logic                onehot_ok
);

    // A pattern with a single set bit becomes zero when its lowest set bit is removed
    assign onehot_ok = (keypad != '0) &&
                       ((keypad & (keypad - NUM_KEYS'(1))) == '0);

    always_comb begin
        bcd = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keypad[i]) begin
                bcd = BCD_W'(i);
            end
        end
    end

endmodule

// File: rtl/keypad_time_encoder.sv
// Debounced 10-key entry that shifts accepted digits into the m:ss time registers.
module keypad_time_encoder
    import timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enablen,
    input  logic                clear,
    input  logic [NUM_KEYS-1:0] keypad,
    output logic [BCD_W-1:0]    sec_ones,
    output logic [BCD_W-1:0]    sec_tens,
    output logic [BCD_W-1:0]    mins,
    output logic                data_valid,
    output logic [BCD_W-1:0]    key_digit
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_KEYS-1:0] pattern_q;
    time_t               time_q;
    logic [BCD_W-1:0]    key_q;
    logic                valid_q;

    logic [BCD_W-1:0]    bcd_c;
    logic                onehot_ok_c;

    keypad_onehot_to_bcd u_dec (
        .keypad    (keypad),
        .bcd       (bcd_c),
        .onehot_ok (onehot_ok_c)
    );

    // Entry FSM, debounce counter and time shift register
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pattern_q <= '0;
            time_q    <= '0;
            key_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!enablen && onehot_ok_c) begin
                        pattern_q <= keypad;
                        cnt_q     <= CNT_W'(1);
                        state_q   <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    // Any change or disable during the window abandons the press
                    if (enablen || (keypad != pattern_q)) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        time_q  <= shift_in(time_q, bcd_c);
                        key_q   <= bcd_c;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Full release required so a held key never repeats
                    if (keypad == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sec_ones   = time_q.sec_ones;
    assign sec_tens   = time_q.sec_tens;
    assign mins       = time_q.mins;
    assign key_digit  = key_q;
    assign data_valid = valid_q;

endmodule

// File: doc/keypad_time_encoder.md
Name: keypad_time_encoder

Overview:
Front-end for the timer display path. It converts a 10-key one-hot keypad into BCD digits and shifts each accepted digit into the time registers sec_ones/sec_tens/mins, microwave-style (new digit enters at sec_ones, older digits move left). These registers feed the 7-segment decoder and the countdown timer load path. Each press is debounced and accepted exactly once.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a key (legal range 2..255)
CNT_W, 8, width of the debounce counter (must hold DEBOUNCE_CYCLES-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enablen  input  1  active-low entry enable; 1 = keypad ignored (timer running)
clear  input  1  synchronous clear of the entered time
keypad  input  10  raw keys, bit i = digit i pressed
sec_ones  output  4  BCD seconds-ones digit
sec_tens  output  4  BCD seconds-tens digit, always 0..5
mins  output  4  BCD minutes digit
data_valid  output  1  one-cycle pulse, a digit was committed
key_digit  output  4  BCD value of the last committed digit

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: all outputs 0, state IDLE, debounce counter 0.
- Priority per edge: reset > clear > enablen/keypad logic.
- clear=1: digits and key_digit go to 0, data_valid 0, state IDLE, counter 0. A press in progress is discarded.
- "Valid pattern" means keypad is exactly one-hot. Zero keys or multi-hot patterns are invalid.
- State IDLE:
  - If enablen=0 and the pattern is valid: latch the pattern, set counter=1, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- State DEBOUNCE:
  - If enablen=1, or keypad differs from the latched pattern: go to IDLE with no commit.
  - Else if counter == DEBOUNCE_CYCLES-1: commit and go to HOLD.
  - Else: counter increments.
- Commit, all on the same edge:
  - mins <= sec_tens
  - sec_tens <= (sec_ones > 5) ? 5 : sec_ones (saturating clamp)
  - sec_ones <= new digit
  - key_digit <= new digit
  - data_valid <= 1
- Latency: with the key stable from sample edge E0, the commit happens on edge E(DEBOUNCE_CYCLES-1). data_valid is high for exactly the following cycle and returns to 0 on the next edge.
- State HOLD: stays in HOLD while keypad is nonzero, including when a different key is added or swapped in. When keypad == 0, go to IDLE. A held key therefore never repeats.
- The old mins digit is discarded on each shift. There is no overflow flag; the fourth and later digits scroll.
- enablen=1 freezes the digits in every state. HOLD still waits for release, so a key held across enablen going low is not accepted.
- Outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package (timer_pkg):
  - state encoding IDLE=2'd0, DEBOUNCE=2'd1, HOLD=2'd2
  - NUM_KEYS=10
  - MAX_SEC_TENS=4'd5
  - BCD digit width 4
- One combinational sub-module, keypad_onehot_to_bcd:
  - input: keypad[9:0]
  - outputs: bcd[3:0] and onehot_ok (exactly one bit set)
  - The top level holds the FSM, debounce counter and shift registers.

Test Plan:
- Reset, then press 1, 2, 3 in turn (each held 6 cycles, 3-cycle gaps) -> mins=1, sec_tens=2, sec_ones=3; exactly three data_valid pulses; key_digit=3.
- Press 7 then 8 -> after the first press sec_ones=7; after the second sec_tens=5 (clamped), sec_ones=8, mins=0.
- Key 4 glitch lasting 3 cycles (less than DEBOUNCE_CYCLES=4) -> no data_valid, digits unchanged. Key 4 held 4 cycles -> commit on the 4th sample edge, data_valid the next cycle.
- keypad=10'b0000000110 held 10 cycles -> no commit. Key 5 held 50 cycles -> exactly one commit. Pressing key 6 while still in HOLD with 5 held -> no commit until all keys release.
- enablen=1 with key 9 held -> digits frozen. enablen dropping mid-DEBOUNCE -> abort, no commit.
- Entered time 1:23, then clear=1 for one cycle -> all digits 0, key_digit=0. Reset asserted during DEBOUNCE -> IDLE with all outputs 0, and no commit even though the key stays held.
